bridge_plant_responder: RTL

Closed-loop emulator of the movable-bridge plant: span, barrier gates and span lock.
- Consumes the bridge controller's actuator commands and returns the sensor levels the controller samples as its x-inputs.
- Instantiated opposite the controller in simulation harnesses and FPGA test rigs; top-level wiring maps sensors to controller inputs.
- Models travel time, command reversal and interlock faults, so controller sequencing, including keyed or altered paths, is exercised against a realistic responder.

---
 rtl/bridge_plant_responder.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bridge_plant_responder.sv
// Closed-loop emulator of the movable-bridge plant: span, barrier gates and span lock.
// It consumes the bridge controller's actuator commands and returns the sensor levels
// that the controller samples. It models travel time, command reversal and sticky
// interlock faults.
//
// Ports:
//   clk, rst                      rising-edge clock; asynchronous active-high reset
//   cmd_raise / cmd_lower         drive the span up / down
//   cmd_gate_close / cmd_gate_open drive the gates closed / open
//   cmd_lock_release / _engage    release / engage the span lock
//   fault_clr                     clears a latched interlock fault
//   span_down, span_up            span position sensors (0 / MOVE_CYCLES)
//   gate_closed, gate_open        gate position sensors (GATE_CYCLES / 0)
//   lock_engaged                  lock fully engaged
//   busy                          span, gate or lock in motion
//   fault                         sticky interlock violation
//   raise_count                   completed raises, saturating
//
// Span states:
//   state     | meaning
//   LOCKED    | span down, lock engaged
//   UNLOCKING | lock releasing, LOCK_CYCLES cycles
//   IDLE      | unlocked, span stationary
//   RAISING   | pos counting up
//   LOWERING  | pos counting down
//   LOCKING   | lock engaging, LOCK_CYCLES cycles
//   FAULT     | interlock violation latched; all motion frozen
//   STOPPED   | fault cleared with span mid-travel
//
// Gate states:
//   state     | meaning
//   G_OPEN    | gpos = 0
//   G_CLOSING | gpos counting up
//   G_CLOSED  | gpos = GATE_CYCLES
//   G_OPENING | gpos counting down
module bridge_plant_responder #(
    parameter int unsigned MOVE_CYCLES = 8,
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned LOCK_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_raise,
    input  logic             cmd_lower,
    input  logic             cmd_gate_close,
    input  logic             cmd_gate_open,
    input  logic             cmd_lock_release,
    input  logic             cmd_lock_engage,
    input  logic             fault_clr,
    output logic             span_down,
    output logic             span_up,
    output logic             gate_closed,
    output logic             gate_open,
    output logic             lock_engaged,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] raise_count
);

    localparam logic [7:0] MOVE_MAX  = 8'(MOVE_CYCLES);
    localparam logic [7:0] GATE_MAX  = 8'(GATE_CYCLES);
    localparam logic [3:0] LOCK_LOAD = 4'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOCKED, S_UNLOCKING, S_IDLE, S_RAISING,
        S_LOWERING, S_LOCKING, S_FAULT, S_STOPPED
    } span_state_t;

    typedef enum logic [1:0] {G_OPEN, G_CLOSING, G_CLOSED, G_OPENING} gate_state_t;

    span_state_t      state_q, state_d;
    gate_state_t      gstate_q, gstate_d;
    logic [7:0]       pos_q, pos_d;
    logic [7:0]       gpos_q, gpos_d;
    logic [3:0]       lcnt_q, lcnt_d;
    logic             lock_q, lock_d;
    logic             ghold_q, ghold_d;   // gate left mid-travel by a fault clear: stationary
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol;
    logic             do_up, do_down, do_gclose, do_gopen;
    logic             gate_moving_d;

    // Interlocks are judged against the sensor levels the controller currently sees.
    assign viol = (cmd_raise & cmd_lower)
                | (cmd_gate_close & cmd_gate_open)
                | (cmd_raise & (lock_engaged | ~gate_closed))
                | (cmd_gate_open & ~span_down)
                | (cmd_lock_engage & ~span_down)
                | (cmd_lock_release & ~gate_closed);

    always_comb begin
        state_d   = state_q;
        gstate_d  = gstate_q;
        pos_d     = pos_q;
        gpos_d    = gpos_q;
        lcnt_d    = lcnt_q;
        lock_d    = lock_q;
        ghold_d   = ghold_q;
        cnt_d     = cnt_q;
        do_up     = 1'b0;
        do_down   = 1'b0;
        do_gclose = 1'b0;
        do_gopen  = 1'b0;

        if (state_q == S_FAULT) begin
            if (fault_clr) begin
                if (pos_q == 8'd0)
                    state_d = lock_q ? S_LOCKED : S_IDLE;
                else if (pos_q == MOVE_MAX)
                    state_d = S_IDLE;
                else
                    state_d = S_STOPPED;
                if (gpos_q == 8'd0) begin
                    gstate_d = G_OPEN;
                    ghold_d  = 1'b0;
                end else if (gpos_q == GATE_MAX) begin
                    gstate_d = G_CLOSED;
                    ghold_d  = 1'b0;
                end else begin
                    ghold_d = 1'b1;
                end
            end
        end else if (viol) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_LOCKED: begin
                    if (cmd_lock_release) begin
                        state_d = S_UNLOCKING;
                        lcnt_d  = LOCK_LOAD;
                    end
                end
                S_UNLOCKING: begin
                    if (lcnt_q == 4'd0) begin
                        state_d = S_IDLE;
                        lock_d  = 1'b0;
                    end else begin
                        lcnt_d = lcnt_q - 4'd1;
                    end
                end
                S_LOCKING: begin
                    if (lcnt_q == 4'd0) begin
                        state_d = S_LOCKED;
                        lock_d  = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q - 4'd1;
                    end
                end
                S_IDLE, S_STOPPED: begin
                    if (cmd_raise && pos_q < MOVE_MAX) begin
                        do_up = 1'b1;
                    end else if (cmd_lower && pos_q != 8'd0) begin
                        do_down = 1'b1;
                    end else if (state_q == S_IDLE && cmd_lock_engage && pos_q == 8'd0) begin
                        state_d = S_LOCKING;
                        lcnt_d  = LOCK_LOAD;
                    end
                end
                // A reversal turns around in place; a completing step takes priority.
                S_RAISING: begin
                    if (cmd_lower && pos_q != MOVE_MAX - 8'd1) state_d = S_LOWERING;
                    else                                       do_up   = 1'b1;
                end
                S_LOWERING: begin
                    if (cmd_raise && pos_q != 8'd1) state_d = S_RAISING;
                    else                            do_down = 1'b1;
                end
                default: state_d = state_q;
            endcase

            if (ghold_q) begin
                if (cmd_gate_close) begin
                    ghold_d   = 1'b0;
                    do_gclose = 1'b1;
                end else if (cmd_gate_open) begin
                    ghold_d  = 1'b0;
                    do_gopen = 1'b1;
                end
            end else begin
                unique case (gstate_q)
                    G_OPEN:    if (cmd_gate_close) do_gclose = 1'b1;
                    G_CLOSED:  if (cmd_gate_open)  do_gopen  = 1'b1;
                    G_CLOSING: begin
                        if (cmd_gate_open && gpos_q != GATE_MAX - 8'd1) gstate_d  = G_OPENING;
                        else                                            do_gclose = 1'b1;
                    end
                    G_OPENING: begin
                        if (cmd_gate_close && gpos_q != 8'd1) gstate_d = G_CLOSING;
                        else                                  do_gopen = 1'b1;
                    end
                    default: gstate_d = gstate_q;
                endcase
            end
        end

        // Each motion step also covers the entry edge, so travel takes exactly N cycles.
        if (do_up) begin
            pos_d = pos_q + 8'd1;
            if (pos_q == MOVE_MAX - 8'd1) begin
                state_d = S_IDLE;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = S_RAISING;
            end
        end
        if (do_down) begin
            pos_d   = pos_q - 8'd1;
            state_d = (pos_q == 8'd1) ? S_IDLE : S_LOWERING;
        end
        if (do_gclose) begin
            gpos_d   = gpos_q + 8'd1;
            gstate_d = (gpos_q == GATE_MAX - 8'd1) ? G_CLOSED : G_CLOSING;
        end
        if (do_gopen) begin
            gpos_d   = gpos_q - 8'd1;
            gstate_d = (gpos_q == 8'd1) ? G_OPEN : G_OPENING;
        end
    end

    assign gate_moving_d = !ghold_d && (state_d != S_FAULT)
                         && (gstate_d == G_CLOSING || gstate_d == G_OPENING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOCKED;
            gstate_q     <= G_OPEN;
            pos_q        <= 8'd0;
            gpos_q       <= 8'd0;
            lcnt_q       <= 4'd0;
            lock_q       <= 1'b1;
            ghold_q      <= 1'b0;
            cnt_q        <= '0;
            span_down    <= 1'b1;
            span_up      <= 1'b0;
            gate_closed  <= 1'b0;
            gate_open    <= 1'b1;
            lock_engaged <= 1'b1;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gstate_q     <= gstate_d;
            pos_q        <= pos_d;
            gpos_q       <= gpos_d;
            lcnt_q       <= lcnt_d;
            lock_q       <= lock_d;
            ghold_q      <= ghold_d;
            cnt_q        <= cnt_d;
            span_down    <= (pos_d == 8'd0);
            span_up      <= (pos_d == MOVE_MAX);
            gate_closed  <= (gpos_d == GATE_MAX);
            gate_open    <= (gpos_d == 8'd0);
            lock_engaged <= lock_d;
            busy         <= (state_d == S_RAISING) || (state_d == S_LOWERING)
                         || (state_d == S_UNLOCKING) || (state_d == S_LOCKING)
                         || gate_moving_d;
            fault        <= (state_d == S_FAULT);
        end
    end

    assign raise_count = cnt_q;

endmodule
